audio_sample_sink: RTL



---
 rtl/audio_sample_sink.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/audio_sample_sink.sv
// audio_sample_sink: memory-mapped multi-channel PCM sink for the picorv32
// look-ahead bus. Firmware pushes samples into per-channel FIFOs and a pacer
// pops one aligned frame every CLKS_PER_SAMPLE cycles toward the DAC side.
// Optional feature macro: AUDIO_SINK_IRQ_EN (low-watermark interrupt); when it
// is undefined irq is tied low and no watermark logic is built.
module audio_sample_sink #(
  parameter int          NUM_CH          = 2,
  parameter int          SAMPLE_W        = 16,
  parameter int          DEPTH           = 16,
  parameter int          CLKS_PER_SAMPLE = 680,
  parameter logic [31:0] BASE_ADDR       = 32'h1000_0000
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [31:0]                  bus_addr,
  input  logic                         bus_read,
  input  logic                         bus_write,
  input  logic [31:0]                  bus_wdata,
  output logic [31:0]                  bus_rdata,
  output logic                         out_valid,
  output logic [NUM_CH*SAMPLE_W-1:0]   out_samples,
  output logic                         out_underflow,
  output logic                         irq
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(CLKS_PER_SAMPLE);
  localparam logic [CW-1:0] RELOAD     = CW'(CLKS_PER_SAMPLE - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  // Bus decode
  logic       sel;
  logic [7:0] offset;
  logic       wr_status;
  logic       wr_ctrl;
  logic       flush;
  logic [NUM_CH-1:0] push_req;

  // FIFO storage and bookkeeping
  logic [SAMPLE_W-1:0] mem [NUM_CH][DEPTH];
  logic [PW-1:0]       wr_ptr [NUM_CH];
  logic [PW-1:0]       rd_ptr [NUM_CH];
  logic [LW-1:0]       level  [NUM_CH];
  logic [NUM_CH-1:0]   full;
  logic [NUM_CH-1:0]   accept;
  logic [NUM_CH-1:0]   overflow_hit;
  logic                all_nonempty;
  logic [LW-1:0]       min_level;
  logic [NUM_CH*SAMPLE_W-1:0] frame;

  // Control, pacer and statistics
  logic              enable;
  logic [CW-1:0]     pace_cnt;
  logic              tick;
  logic              pop;
  logic              underrun;
  logic [15:0]       uf_count;
  logic [NUM_CH-1:0] ovf;
  logic [7:0]        ovf8;
  logic [31:0]       rd_mux;
  logic              unused_wdata;

  assign sel       = (bus_addr[31:8] == BASE_ADDR[31:8]);
  assign offset    = bus_addr[7:0];
  assign wr_status = bus_write && sel && (offset == 8'h00);
  assign wr_ctrl   = bus_write && sel && (offset == 8'h04);
  assign flush     = wr_ctrl && bus_wdata[1];
  assign unused_wdata = ^bus_wdata;

  // Each channel's DATA register sits at 0x10 + 0x10*c
  always_comb begin
    push_req = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      push_req[c] = bus_write && sel && (offset == 8'((c + 1) * 16));
    end
  end

  // Per-channel fill state, minimum level and the frame at the FIFO heads
  always_comb begin
    all_nonempty = 1'b1;
    min_level    = level[0];
    full         = '0;
    frame        = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (level[c] == '0) all_nonempty = 1'b0;
      if (level[c] < min_level) min_level = level[c];
      full[c] = (level[c] == FULL_LEVEL);
      frame[c*SAMPLE_W +: SAMPLE_W] = mem[c][rd_ptr[c]];
    end
  end

  // A flush on the tick cycle suppresses the pop so channels stay aligned
  assign tick         = enable && (pace_cnt == '0);
  assign pop          = tick && all_nonempty && !flush;
  assign underrun     = tick && !pop;
  assign accept       = push_req & (~full | {NUM_CH{pop}});
  assign overflow_hit = push_req & full & ~{NUM_CH{pop}};

  // Sample storage write port; contents need no reset
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (accept[c]) mem[c][wr_ptr[c]] <= bus_wdata[SAMPLE_W-1:0];
    end
  end

  // Pointer and level tracking; a flush empties every channel at once
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        level[c]  <= '0;
      end
    end else if (flush) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        level[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (accept[c]) wr_ptr[c] <= wr_ptr[c] + PW'(1);
        if (pop)       rd_ptr[c] <= rd_ptr[c] + PW'(1);
        case ({accept[c], pop})
          2'b10:   level[c] <= level[c] + LW'(1);
          2'b01:   level[c] <= level[c] - LW'(1);
          default: level[c] <= level[c];
        endcase
      end
    end
  end

  // Enable bit; flush is a strobe and is never stored
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      enable <= 1'b0;
    else if (wr_ctrl) enable <= bus_wdata[0];
  end

  // Pacer down-counter parked at reload while disabled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               pace_cnt <= RELOAD;
    else if (!enable)          pace_cnt <= RELOAD;
    else if (pace_cnt == '0)   pace_cnt <= RELOAD;
    else                       pace_cnt <= pace_cnt - CW'(1);
  end

  // Underflow counter and sticky overflow bits; a STATUS write clears both
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      uf_count <= '0;
      ovf      <= '0;
    end else if (wr_status) begin
      uf_count <= '0;
      ovf      <= '0;
    end else begin
      if (underrun && (uf_count != 16'hFFFF)) uf_count <= uf_count + 16'd1;
      ovf <= ovf | overflow_hit;
    end
  end

  // Output frame register; a repeat frame keeps the previous samples
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid     <= 1'b0;
      out_underflow <= 1'b0;
      out_samples   <= '0;
    end else begin
      out_valid     <= tick;
      out_underflow <= underrun;
      if (pop) out_samples <= frame;
    end
  end

  // Register read multiplexer
  always_comb begin
    ovf8   = '0;
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) ovf8[c] = ovf[c];
    case (offset)
      8'h00:   rd_mux = {uf_count, ovf8, 8'(min_level)};
      8'h04:   rd_mux = {31'd0, enable};
      default: rd_mux = '0;
    endcase
  end

  // Registered read data, held between reads
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)               bus_rdata <= '0;
    else if (bus_read && sel)  bus_rdata <= rd_mux;
  end

`ifdef AUDIO_SINK_IRQ_EN
  // Low-watermark interrupt while running with the emptiest FIFO at half or below
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) irq <= 1'b0;
    else         irq <= enable && (min_level <= LW'(DEPTH / 2));
  end
`else
  assign irq = 1'b0;
`endif

endmodule
